// File: rtl/instr_fetch.sv
// IF stage: owns the PC, keeps up to FIFO_DEPTH imem requests in flight, buffers
// returned words and feeds IF/ID. Optional FETCH_ALIGN_CHECK_EN flags misaligned redirect targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_we,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_flush,
  output logic        o_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = FIFO_DEPTH[CW:0];
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW-1:0] r_tag_rd, r_tag_wr;
  entry_t        r_fifo [FIFO_DEPTH];
  logic [31:0]   r_tag  [FIFO_DEPTH];

  logic        w_credit;
  logic        w_req;
  logic        w_grant;
  logic        w_rvalid;
  logic        w_keep;
  logic        w_pop;
  logic [31:0] w_target;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
  assign w_req    = !i_rst && !i_redirect && w_credit;
  assign w_grant  = w_req && i_imem_gnt;
  assign w_rvalid = i_imem_rvalid && (r_outstanding != '0);
  assign w_keep   = w_rvalid && (r_discard == '0) && !i_redirect;
  assign w_pop    = !i_rst && (r_count != '0) && !i_stall && !i_redirect;
  assign w_target = i_redirect_pc & ~32'h3;

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_we        = w_pop;
  assign o_flush     = !i_rst && i_redirect;

`ifdef FETCH_ALIGN_CHECK_EN
  assign o_misalign = !i_rst && i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
  assign o_misalign = 1'b0;
`endif

  // NOTE: outputs get a default before the if, so no path leaves them unassigned (no latch).
  always_comb begin
    o_instr = 32'h0;
    o_pc    = 32'h0;
    if (r_count != '0) begin
      o_instr = r_fifo[r_rd_ptr].instr;
      o_pc    = r_fifo[r_rd_ptr].pc4;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rvalid);
      if (w_grant)  r_tag_wr <= next_ptr(r_tag_wr);
      if (w_rvalid) r_tag_rd <= next_ptr(r_tag_rd);

      if (i_redirect)   r_pc <= w_target;
      else if (w_grant) r_pc <= r_pc + 32'd4;

      // Every request still outstanding after a redirect belongs to the old path.
      if (i_redirect)                         r_discard <= r_outstanding - CW'(w_rvalid);
      else if (w_rvalid && r_discard != '0)   r_discard <= r_discard - CW'(1);

      if (i_redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_keep) r_wr_ptr <= next_ptr(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
        r_count <= r_count + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; the counters and pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_grant)           r_tag[r_tag_wr]  <= r_pc + 32'd4;
    if (w_keep && !i_rst)  r_fifo[r_wr_ptr] <= {i_imem_rdata, r_tag[r_tag_rd]};
  end

`ifndef SYNTHESIS
  a_no_spurious_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (r_outstanding != '0));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: request-level memory model plus an epoch-tagged
// scoreboard of the instructions IF/ID should receive.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        i_rst, i_stall, i_redirect, i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_req, o_we, o_flush, o_misalign;
  logic [31:0] o_imem_addr, o_instr, o_pc;

  instr_fetch dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_we(o_we), .o_instr(o_instr), .o_pc(o_pc), .o_flush(o_flush), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } sb_t;

  req_t        memq[$];
  sb_t         sb[$];
  int          epoch, cyc, first_we, n_checks, n_pass;
  logic [31:0] next_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    check("rst_req",      32'(o_imem_req), 32'h0);
    check("rst_we",       32'(o_we),       32'h0);
    check("rst_instr",    o_instr,         32'h0);
    check("rst_pc",       o_pc,            32'h0);
    check("rst_flush",    32'(o_flush),    32'h0);
    check("rst_misalign", 32'(o_misalign), 32'h0);
    i_rst = 1'b0;
    memq.delete(); sb.delete();
    epoch++; next_addr = 32'h0; cyc = 0; first_we = 0;
  endtask

  task automatic step(input int p_gnt, input int p_rv, input int p_stall, input int p_redir,
                      input bit force_redir, input logic [31:0] force_tgt);
    logic        exp_req, exp_we, exp_mis, grant;
    logic [31:0] exp_i, exp_p;
    req_t        r;
    @(negedge clk);
    cyc++;
    i_stall    = ($urandom_range(99) < p_stall);
    i_redirect = force_redir || ($urandom_range(99) < p_redir);
    if (force_redir)                  i_redirect_pc = force_tgt;
    else if ($urandom_range(3) == 0)  i_redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
    else                              i_redirect_pc = $urandom() & 32'h0000_0FFF;
    i_imem_gnt    = ($urandom_range(99) < p_gnt);
    i_imem_rvalid = (memq.size() > 0) && (memq[0].due <= cyc) && ($urandom_range(99) < p_rv);
    i_imem_rdata  = i_imem_rvalid ? mem_word(memq[0].addr) : $urandom();
    #1;
    exp_req = !i_redirect && (memq.size() + sb.size() < 2);
    exp_we  = (sb.size() > 0) && !i_stall && !i_redirect;
    exp_i   = (sb.size() > 0) ? sb[0].instr : 32'h0;
    exp_p   = (sb.size() > 0) ? sb[0].pc4   : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_mis = i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
    exp_mis = 1'b0;
`endif
    check("flush",    32'(o_flush),    32'(i_redirect));
    check("misalign", 32'(o_misalign), 32'(exp_mis));
    check("req",      32'(o_imem_req), 32'(exp_req));
    if (exp_req) check("addr", o_imem_addr, next_addr);
    check("we",    32'(o_we), 32'(exp_we));
    check("instr", o_instr,   exp_i);
    check("pc",    o_pc,      exp_p);
    if (o_we && first_we == 0) first_we = cyc;

    // Advance the reference: consume, collect responses, then redirect or grant.
    grant = o_imem_req && i_imem_gnt;
    if (exp_we) void'(sb.pop_front());
    if (i_imem_rvalid) begin
      r = memq.pop_front();
      if (!i_redirect && r.epoch == epoch) sb.push_back('{mem_word(r.addr), r.addr + 32'd4});
    end
    if (i_redirect) begin
      sb.delete();
      epoch++;
      next_addr = i_redirect_pc & ~32'h3;
    end else if (grant) begin
      memq.push_back('{next_addr, epoch, cyc + 1});
      next_addr = next_addr + 32'd4;
    end
  endtask

  task automatic run(input int n, input int p_gnt, input int p_rv, input int p_stall,
                     input int p_redir);
    for (int i = 0; i < n; i++) step(p_gnt, p_rv, p_stall, p_redir, 1'b0, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; epoch = 0;
    do_reset();

    // Ideal memory: first IF/ID write lands in cycle 3.
    run(30, 100, 100, 0, 0);
    check("first_we", 32'(first_we), 32'd3);

    run(40, 25, 70, 0, 0);    // grant often withheld
    run(40, 100, 100, 70, 0); // heavy stall

    // Redirect to 0x400 while two requests are in flight.
    for (int i = 0; i < 12 && memq.size() != 2; i++) step(100, 0, 0, 0, 1'b0, 32'h0);
    check("inflight2", 32'(memq.size()), 32'd2);
    step(100, 100, 0, 0, 1'b1, 32'h0000_0400);
    run(20, 100, 100, 0, 0);

    step(100, 100, 0, 0, 1'b1, 32'h0000_0402);
    run(10, 100, 100, 0, 0);
    step(100, 100, 0, 0, 1'b1, 32'hFFFF_FFF8);
    run(12, 100, 100, 0, 0);

    run(600, 60, 60, 20, 4);
    do_reset();
    run(60, 60, 60, 20, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
